irq_pending_latch: RTL and testbench
====================================

Name: irq_pending_latch

Overview:
- Request-side partner of the interrupt priority encoder.
- Turns raw peripheral event lines into sticky per-line pending bits; those bits feed the encoder's request vector.
- Takes back the encoded code the CPU acknowledges, decodes it to one-hot, clears that pending bit and emits a one-cycle acknowledge pulse to the originating peripheral.
- Sits between the peripheral event lines and the priority encoder, on the CPU clock domain.

Parameters:
NUM_INPUTS, 16, number of request lines; legal range 1..65536
TOP_INPUT, NUM_INPUTS-1, index of the highest request line (derived; do not override)

Ports:
sysclk  in  1  system clock; all state updates on its rising edge
sysreset_n  in  1  asynchronous, active-low reset
irq_in  in  NUM_INPUTS  raw event lines; a rising edge is one event
irq_enable  in  NUM_INPUTS  per-line mask; 1 = edges on that line are latched
ack_strobe  in  1  one-cycle acknowledge strobe from the CPU
ack_code  in  16  encoded line number being acknowledged; sampled only while ack_strobe=1
clear_overflow  in  1  one-cycle strobe; clears every overflow bit
pending  out  NUM_INPUTS  sticky pending bits; drives the encoder's request vector
any_pending  out  1  OR of pending (combinational from the pending register)
ack_onehot  out  NUM_INPUTS  one-hot acknowledge pulse, one cycle wide
ack_error  out  1  one-cycle pulse flagging a bad acknowledge
overflow  out  NUM_INPUTS  sticky: an event arrived while that line was already pending

Behaviour:
- Reset (async assert, sync release):
  - pending, ack_onehot, ack_error, overflow and the edge-history register all clear to 0.
  - Reset mid-operation aborts any in-flight ack pulse immediately.
- Edge-history reset value 0 is deliberate: a line already high at reset release counts as an edge on the first clock, so a request held through reset is not lost.
- Edge detect: rise = irq_in & ~prev; prev <= irq_in every cycle, independent of irq_enable.
- Clear term: clr = one-hot decode of ack_code, gated by ack_strobe and by ack_code < NUM_INPUTS.
- Pending update: pending <= (pending & ~clr) | (rise & irq_enable).
  - A masked edge is dropped, not deferred; later enabling the line does not resurrect it.
  - Set wins over clear on the same bit in the same cycle, since the new edge is a fresh event. The ack pulse still issues.
  - Deasserting irq_enable does not clear an existing pending bit.
- Acknowledge latency:
  - The strobe is sampled at edge N.
  - At edge N the pending bit clears, and ack_onehot/ack_error register.
  - Both the clear and the pulses are visible during cycle N+1 and last exactly one cycle.
  - Back-to-back strobes on consecutive cycles are legal; each produces its own pulse, with no stall and no ready signal.
- Bad acknowledge:
  - ack_code >= NUM_INPUTS: no clear, ack_onehot stays 0, ack_error pulses.
  - Valid code whose bit is not pending: ack_onehot pulses anyway and ack_error also pulses.
- Code 0 is a real line: acknowledging 0 clears bit 0. An acknowledge with ack_strobe=0 is ignored regardless of ack_code.
- Overflow:
  - Set condition: overflow[i] <= 1 when rise[i] & irq_enable[i] & pending[i] & ~clr[i].
  - Clear: clear_overflow clears all bits; a set wins over clear_overflow in the same cycle.
  - Overflow never affects pending.
- Width rules:
  - ack_code is always 16 bits.
  - When NUM_INPUTS < 65536, compare the full 16-bit value against NUM_INPUTS; do not truncate before the range check.

Optional Feature:
- Macro: IRQ_PENDING_SYNC_EN.
- Defined: irq_in passes through a 2-flop synchronizer (reset 0) before edge detect. Edge-to-pending latency becomes 3 clocks, and async peripheral lines are safe.
- Undefined: irq_in feeds edge detect directly; edge-to-pending latency is 1 clock. irq_in must then be synchronous to sysclk.

Decomposition:
- Shared package irq_pkg:
  - IRQ_CODE_W = 16.
  - IRQ_MAX_INPUTS = 65536.
  - A function decoding a 16-bit code to a NUM_INPUTS-wide one-hot vector with an in-range flag.
- One natural sub-module, irq_edge_sync: the optional synchronizer plus history register, producing rise.

Test Plan (NUM_INPUTS=16 unless stated):
- Enable=16'hFFFF, pulse irq_in[5] high 1 cycle -> pending=16'h0020 next cycle (3 cycles with sync), any_pending=1; ack_strobe with code 5 -> pending=0 and ack_onehot=16'h0020 for exactly one cycle.
- irq_enable[3]=0, rising edge on irq_in[3], then set irq_enable[3]=1 -> pending stays 0.
- pending[7]=1, rising edge on irq_in[7] -> overflow=16'h0080 sticky; clear_overflow -> overflow=0, pending[7] still 1.
- Rising edge on irq_in[2] in the same cycle as ack of code 2 -> pending[2] remains 1, ack_onehot=16'h0004, overflow[2]=0.
- ack_code=16 with strobe -> ack_error=1 for one cycle, ack_onehot=0, pending unchanged; ack of non-pending code 9 -> ack_onehot=16'h0200 and ack_error=1.
- irq_in[0] held high through reset, release sysreset_n -> pending[0]=1 after first edge; assert sysreset_n low mid ack pulse -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt request path: code width, line-count
// ceiling and the acknowledge-code range check.
package irq_pkg;

  localparam int IRQ_CODE_W     = 16;
  localparam int IRQ_MAX_INPUTS = 65536;

  typedef logic [IRQ_CODE_W-1:0] irq_code_t;

  // True when the full 16-bit code names an existing line. The compare is
  // done at 32 bits so an out-of-range code is never aliased onto a low line.
  function automatic logic irq_code_in_range(input irq_code_t code,
                                             input int unsigned num_inputs);
    if (num_inputs >= IRQ_MAX_INPUTS) return 1'b1;
    return (32'(code) < num_inputs);
  endfunction

endpackage

// File: rtl/irq_edge_sync.sv
// Rising-edge detector for the raw event lines.
// With IRQ_PENDING_SYNC_EN defined a 2-flop synchronizer sits ahead of the
// history register, so asynchronous peripheral lines are safe (3-clock
// edge-to-pending latency); otherwise irq_i must be synchronous to sysclk.
// History resets to 0 so a line held high through reset yields an edge.
module irq_edge_sync #(
  parameter int W = 16
) (
  input  logic         sysclk,
  input  logic         sysreset_n,
  input  logic [W-1:0] irq_i,
  output logic [W-1:0] rise_o
);

  logic [W-1:0] level;
  logic [W-1:0] prev_q;

`ifdef IRQ_PENDING_SYNC_EN
  logic [W-1:0] sync1_q;
  logic [W-1:0] sync2_q;

  // Two-stage synchronizer for asynchronous event lines
  always_ff @(posedge sysclk or negedge sysreset_n) begin
    if (!sysreset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_i;
      sync2_q <= sync1_q;
    end
  end

  assign level = sync2_q;
`else
  assign level = irq_i;
`endif

  // Edge history, updated every cycle regardless of any mask
  always_ff @(posedge sysclk or negedge sysreset_n) begin
    if (!sysreset_n) prev_q <= '0;
    else             prev_q <= level;
  end

  assign rise_o = level & ~prev_q;

endmodule

// File: rtl/irq_pending_latch.sv
// Sticky per-line interrupt pending latch with encoded acknowledge.
// Edges on enabled lines set pending bits; an acknowledged code clears its
// bit and returns a one-cycle one-hot pulse (or an error pulse when the code
// is out of range or not pending). A new edge wins over a same-cycle clear.
// Optional input synchronizer: IRQ_PENDING_SYNC_EN (see irq_edge_sync).
module irq_pending_latch
  import irq_pkg::*;
#(
  parameter  int NUM_INPUTS = 16,
  localparam int TOP_INPUT  = NUM_INPUTS - 1
) (
  input  logic                  sysclk,
  input  logic                  sysreset_n,
  input  logic [TOP_INPUT:0]    irq_in,
  input  logic [TOP_INPUT:0]    irq_enable,
  input  logic                  ack_strobe,
  input  logic [IRQ_CODE_W-1:0] ack_code,
  input  logic                  clear_overflow,
  output logic [TOP_INPUT:0]    pending,
  output logic                  any_pending,
  output logic [TOP_INPUT:0]    ack_onehot,
  output logic                  ack_error,
  output logic [TOP_INPUT:0]    overflow
);

  logic [TOP_INPUT:0] rise;
  logic [TOP_INPUT:0] clr;
  logic [TOP_INPUT:0] set_mask;
  logic [TOP_INPUT:0] pending_d, pending_q;
  logic [TOP_INPUT:0] overflow_d, overflow_q;
  logic [TOP_INPUT:0] ack_onehot_q;
  logic               ack_error_d, ack_error_q;
  logic               code_ok;

  irq_edge_sync #(.W(NUM_INPUTS)) u_edge (
    .sysclk     (sysclk),
    .sysreset_n (sysreset_n),
    .irq_i      (irq_in),
    .rise_o     (rise)
  );

  // Decode the acknowledged code into a strobe-gated one-hot clear
  always_comb begin
    code_ok = irq_code_in_range(ack_code, NUM_INPUTS);
    clr     = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      clr[i] = ack_strobe & code_ok & (ack_code == IRQ_CODE_W'(i));
    end
  end

  // Next-state for pending, overflow and the acknowledge error
  always_comb begin
    set_mask    = rise & irq_enable;
    pending_d   = (pending_q & ~clr) | set_mask;
    overflow_d  = (clear_overflow ? '0 : overflow_q) | (set_mask & pending_q & ~clr);
    ack_error_d = ack_strobe & ~(|(clr & pending_q));
  end

  // State registers; reset also kills any in-flight acknowledge pulse
  always_ff @(posedge sysclk or negedge sysreset_n) begin
    if (!sysreset_n) begin
      pending_q    <= '0;
      overflow_q   <= '0;
      ack_onehot_q <= '0;
      ack_error_q  <= 1'b0;
    end else begin
      pending_q    <= pending_d;
      overflow_q   <= overflow_d;
      ack_onehot_q <= clr;
      ack_error_q  <= ack_error_d;
    end
  end

  assign pending     = pending_q;
  assign any_pending = |pending_q;
  assign ack_onehot  = ack_onehot_q;
  assign ack_error   = ack_error_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_irq_pending_latch.sv
// Self-checking bench for irq_pending_latch (NUM_INPUTS=16).
module tb_irq_pending_latch;

`ifdef IRQ_PENDING_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic        sysclk = 1'b0;
  logic        sysreset_n;
  logic [15:0] irq_in;
  logic [15:0] irq_enable;
  logic        ack_strobe;
  logic [15:0] ack_code;
  logic        clear_overflow;
  logic [15:0] pending;
  logic        any_pending;
  logic [15:0] ack_onehot;
  logic        ack_error;
  logic [15:0] overflow;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       nm;
    bit          w;
    logic [15:0] irq, en;
    logic        stb;
    logic [15:0] code;
    logic        clr;
    logic [15:0] ep, eoh;
    logic        eerr;
    logic [15:0] eovf;
  } row_t;

  typedef struct {
    string       nm;
    logic [15:0] ep, eoh;
    logic        eerr;
    logic [15:0] eovf;
  } exp_t;

  exp_t sb[$];

  irq_pending_latch #(.NUM_INPUTS(16)) dut (
    .sysclk         (sysclk),
    .sysreset_n     (sysreset_n),
    .irq_in         (irq_in),
    .irq_enable     (irq_enable),
    .ack_strobe     (ack_strobe),
    .ack_code       (ack_code),
    .clear_overflow (clear_overflow),
    .pending        (pending),
    .any_pending    (any_pending),
    .ack_onehot     (ack_onehot),
    .ack_error      (ack_error),
    .overflow       (overflow)
  );

  always #5 sysclk = ~sysclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic row_t mk(string nm, bit w, logic [15:0] irq, logic [15:0] en,
                              logic stb, logic [15:0] code, logic clr,
                              logic [15:0] ep, logic [15:0] eoh, logic eerr,
                              logic [15:0] eovf);
    row_t r;
    r.nm = nm; r.w = w; r.irq = irq; r.en = en; r.stb = stb; r.code = code;
    r.clr = clr; r.ep = ep; r.eoh = eoh; r.eerr = eerr; r.eovf = eovf;
    return r;
  endfunction

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  // Drive one row: optional settle cycles for the edge path, then the
  // checked cycle; the expectation goes to the scoreboard before the edge.
  task automatic apply_row(input row_t r);
    if (r.w) begin
      irq_in = r.irq; irq_enable = r.en; ack_strobe = 1'b0; clear_overflow = 1'b0;
      repeat (LAT - 1) tick();
    end
    irq_in = r.irq; irq_enable = r.en; ack_strobe = r.stb; ack_code = r.code;
    clear_overflow = r.clr;
    sb.push_back('{r.nm, r.ep, r.eoh, r.eerr, r.eovf});
    tick();
    ack_strobe = 1'b0;
    clear_overflow = 1'b0;
  endtask

  task automatic test_reset();
    row_t rows[$];
    exp_t e;
    sysreset_n = 1'b0; irq_in = 16'h0001; irq_enable = 16'hFFFF;
    ack_strobe = 1'b0; ack_code = 16'h0; clear_overflow = 1'b0;
    sb.push_back('{"reset_state", 16'h0, 16'h0, 1'b0, 16'h0});
    repeat (2) tick();
    e = sb.pop_front();
    checks++;
    if ({pending, any_pending, ack_onehot, ack_error, overflow} !== {e.ep, |e.ep, e.eoh, e.eerr, e.eovf}) begin
      errors++;
      $display("FAIL %s: got pend=%h any=%b oh=%h err=%b ovf=%h want pend=%h oh=%h err=%b ovf=%h",
               e.nm, pending, any_pending, ack_onehot, ack_error, overflow, e.ep, e.eoh, e.eerr, e.eovf);
    end
    sysreset_n = 1'b1;
    rows.push_back(mk("held_thru_reset", 1, 16'h0001, 16'hFFFF, 0, 16'h0, 0, 16'h0001, 16'h0, 0, 16'h0));
    rows.push_back(mk("ack_code0",       0, 16'h0001, 16'hFFFF, 1, 16'h0, 0, 16'h0000, 16'h0001, 0, 16'h0));
    rows.push_back(mk("ack0_pulse_end",  0, 16'h0000, 16'hFFFF, 0, 16'h0, 0, 16'h0000, 16'h0, 0, 16'h0));
    foreach (rows[k]) begin
      apply_row(rows[k]);
      e = sb.pop_front();
      checks++;
      if ({pending, any_pending, ack_onehot, ack_error, overflow} !== {e.ep, |e.ep, e.eoh, e.eerr, e.eovf}) begin
        errors++;
        $display("FAIL %s: got pend=%h any=%b oh=%h err=%b ovf=%h want pend=%h oh=%h err=%b ovf=%h",
                 e.nm, pending, any_pending, ack_onehot, ack_error, overflow, e.ep, e.eoh, e.eerr, e.eovf);
      end
    end
  endtask

  task automatic test_basic();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk("edge5_pending",  1, 16'h0020, 16'hFFFF, 0, 16'h0, 0, 16'h0020, 16'h0, 0, 16'h0));
    rows.push_back(mk("edge5_sticky",   1, 16'h0000, 16'hFFFF, 0, 16'h0, 0, 16'h0020, 16'h0, 0, 16'h0));
    rows.push_back(mk("ack5",           0, 16'h0000, 16'hFFFF, 1, 16'h5, 0, 16'h0000, 16'h0020, 0, 16'h0));
    rows.push_back(mk("ack5_one_cycle", 0, 16'h0000, 16'hFFFF, 0, 16'h5, 0, 16'h0000, 16'h0, 0, 16'h0));
    foreach (rows[k]) begin
      apply_row(rows[k]);
      e = sb.pop_front();
      checks++;
      if ({pending, any_pending, ack_onehot, ack_error, overflow} !== {e.ep, |e.ep, e.eoh, e.eerr, e.eovf}) begin
        errors++;
        $display("FAIL %s: got pend=%h any=%b oh=%h err=%b ovf=%h want pend=%h oh=%h err=%b ovf=%h",
                 e.nm, pending, any_pending, ack_onehot, ack_error, overflow, e.ep, e.eoh, e.eerr, e.eovf);
      end
    end
  endtask

  task automatic test_mask();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk("masked_edge3",    1, 16'h0008, 16'hFFF7, 0, 16'h0, 0, 16'h0000, 16'h0, 0, 16'h0));
    rows.push_back(mk("unmask_no_edge",  0, 16'h0008, 16'hFFFF, 0, 16'h0, 0, 16'h0000, 16'h0, 0, 16'h0));
    rows.push_back(mk("unmask_drop",     1, 16'h0000, 16'hFFFF, 0, 16'h0, 0, 16'h0000, 16'h0, 0, 16'h0));
    rows.push_back(mk("edge4",           1, 16'h0010, 16'hFFFF, 0, 16'h0, 0, 16'h0010, 16'h0, 0, 16'h0));
    rows.push_back(mk("disable_keeps",   1, 16'h0000, 16'h0000, 0, 16'h0, 0, 16'h0010, 16'h0, 0, 16'h0));
    rows.push_back(mk("ack4",            0, 16'h0000, 16'hFFFF, 1, 16'h4, 0, 16'h0000, 16'h0010, 0, 16'h0));
    foreach (rows[k]) begin
      apply_row(rows[k]);
      e = sb.pop_front();
      checks++;
      if ({pending, any_pending, ack_onehot, ack_error, overflow} !== {e.ep, |e.ep, e.eoh, e.eerr, e.eovf}) begin
        errors++;
        $display("FAIL %s: got pend=%h any=%b oh=%h err=%b ovf=%h want pend=%h oh=%h err=%b ovf=%h",
                 e.nm, pending, any_pending, ack_onehot, ack_error, overflow, e.ep, e.eoh, e.eerr, e.eovf);
      end
    end
  endtask

  task automatic test_overflow();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk("ovf_first_edge",  1, 16'h0080, 16'hFFFF, 0, 16'h0, 0, 16'h0080, 16'h0, 0, 16'h0000));
    rows.push_back(mk("ovf_low",         1, 16'h0000, 16'hFFFF, 0, 16'h0, 0, 16'h0080, 16'h0, 0, 16'h0000));
    rows.push_back(mk("ovf_second_edge", 1, 16'h0080, 16'hFFFF, 0, 16'h0, 0, 16'h0080, 16'h0, 0, 16'h0080));
    rows.push_back(mk("ovf_sticky",      1, 16'h0000, 16'hFFFF, 0, 16'h0, 0, 16'h0080, 16'h0, 0, 16'h0080));
    rows.push_back(mk("ovf_clear",       0, 16'h0000, 16'hFFFF, 0, 16'h0, 1, 16'h0080, 16'h0, 0, 16'h0000));
    rows.push_back(mk("ovf_set_wins",    1, 16'h0080, 16'hFFFF, 0, 16'h0, 1, 16'h0080, 16'h0, 0, 16'h0080));
    rows.push_back(mk("ovf_clear2",      1, 16'h0000, 16'hFFFF, 0, 16'h0, 1, 16'h0080, 16'h0, 0, 16'h0000));
    rows.push_back(mk("ack7",            0, 16'h0000, 16'hFFFF, 1, 16'h7, 0, 16'h0000, 16'h0080, 0, 16'h0000));
    rows.push_back(mk("ack7_end",        0, 16'h0000, 16'hFFFF, 0, 16'h0, 0, 16'h0000, 16'h0, 0, 16'h0000));
    foreach (rows[k]) begin
      apply_row(rows[k]);
      e = sb.pop_front();
      checks++;
      if ({pending, any_pending, ack_onehot, ack_error, overflow} !== {e.ep, |e.ep, e.eoh, e.eerr, e.eovf}) begin
        errors++;
        $display("FAIL %s: got pend=%h any=%b oh=%h err=%b ovf=%h want pend=%h oh=%h err=%b ovf=%h",
                 e.nm, pending, any_pending, ack_onehot, ack_error, overflow, e.ep, e.eoh, e.eerr, e.eovf);
      end
    end
  endtask

  task automatic test_set_wins();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk("edge2",          1, 16'h0004, 16'hFFFF, 0, 16'h0, 0, 16'h0004, 16'h0, 0, 16'h0));
    rows.push_back(mk("edge2_low",      1, 16'h0000, 16'hFFFF, 0, 16'h0, 0, 16'h0004, 16'h0, 0, 16'h0));
    rows.push_back(mk("edge2_with_ack", 1, 16'h0004, 16'hFFFF, 1, 16'h2, 0, 16'h0004, 16'h0004, 0, 16'h0));
    rows.push_back(mk("set_wins_after", 1, 16'h0000, 16'hFFFF, 0, 16'h0, 0, 16'h0004, 16'h0, 0, 16'h0));
    rows.push_back(mk("ack2",           0, 16'h0000, 16'hFFFF, 1, 16'h2, 0, 16'h0000, 16'h0004, 0, 16'h0));
    foreach (rows[k]) begin
      apply_row(rows[k]);
      e = sb.pop_front();
      checks++;
      if ({pending, any_pending, ack_onehot, ack_error, overflow} !== {e.ep, |e.ep, e.eoh, e.eerr, e.eovf}) begin
        errors++;
        $display("FAIL %s: got pend=%h any=%b oh=%h err=%b ovf=%h want pend=%h oh=%h err=%b ovf=%h",
                 e.nm, pending, any_pending, ack_onehot, ack_error, overflow, e.ep, e.eoh, e.eerr, e.eovf);
      end
    end
  endtask

  task automatic test_bad_ack();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk("edge1",          1, 16'h0002, 16'hFFFF, 0, 16'h0000, 0, 16'h0002, 16'h0000, 0, 16'h0));
    rows.push_back(mk("edge1_low",      1, 16'h0000, 16'hFFFF, 0, 16'h0000, 0, 16'h0002, 16'h0000, 0, 16'h0));
    rows.push_back(mk("ack_code16",     0, 16'h0000, 16'hFFFF, 1, 16'h0010, 0, 16'h0002, 16'h0000, 1, 16'h0));
    rows.push_back(mk("ack_err_end",    0, 16'h0000, 16'hFFFF, 0, 16'h0010, 0, 16'h0002, 16'h0000, 0, 16'h0));
    rows.push_back(mk("ack_codeFFFF",   0, 16'h0000, 16'hFFFF, 1, 16'hFFFF, 0, 16'h0002, 16'h0000, 1, 16'h0));
    rows.push_back(mk("ack_code0011",   0, 16'h0000, 16'hFFFF, 1, 16'h0011, 0, 16'h0002, 16'h0000, 1, 16'h0));
    rows.push_back(mk("ack_nonpend9",   0, 16'h0000, 16'hFFFF, 1, 16'h0009, 0, 16'h0002, 16'h0200, 1, 16'h0));
    rows.push_back(mk("no_strobe_code1",0, 16'h0000, 16'hFFFF, 0, 16'h0001, 0, 16'h0002, 16'h0000, 0, 16'h0));
    foreach (rows[k]) begin
      apply_row(rows[k]);
      e = sb.pop_front();
      checks++;
      if ({pending, any_pending, ack_onehot, ack_error, overflow} !== {e.ep, |e.ep, e.eoh, e.eerr, e.eovf}) begin
        errors++;
        $display("FAIL %s: got pend=%h any=%b oh=%h err=%b ovf=%h want pend=%h oh=%h err=%b ovf=%h",
                 e.nm, pending, any_pending, ack_onehot, ack_error, overflow, e.ep, e.eoh, e.eerr, e.eovf);
      end
    end
  endtask

  task automatic test_back_to_back();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk("edge10",     1, 16'h0400, 16'hFFFF, 0, 16'h0, 0, 16'h0402, 16'h0000, 0, 16'h0));
    rows.push_back(mk("edge10_low", 1, 16'h0000, 16'hFFFF, 0, 16'h0, 0, 16'h0402, 16'h0000, 0, 16'h0));
    rows.push_back(mk("b2b_ack1",   0, 16'h0000, 16'hFFFF, 1, 16'h1, 0, 16'h0400, 16'h0002, 0, 16'h0));
    rows.push_back(mk("b2b_ack10",  0, 16'h0000, 16'hFFFF, 1, 16'hA, 0, 16'h0000, 16'h0400, 0, 16'h0));
    rows.push_back(mk("b2b_end",    0, 16'h0000, 16'hFFFF, 0, 16'h0, 0, 16'h0000, 16'h0000, 0, 16'h0));
    foreach (rows[k]) begin
      apply_row(rows[k]);
      e = sb.pop_front();
      checks++;
      if ({pending, any_pending, ack_onehot, ack_error, overflow} !== {e.ep, |e.ep, e.eoh, e.eerr, e.eovf}) begin
        errors++;
        $display("FAIL %s: got pend=%h any=%b oh=%h err=%b ovf=%h want pend=%h oh=%h err=%b ovf=%h",
                 e.nm, pending, any_pending, ack_onehot, ack_error, overflow, e.ep, e.eoh, e.eerr, e.eovf);
      end
    end
  endtask

  task automatic test_reset_mid_ack();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk("edge6",      1, 16'h0040, 16'hFFFF, 0, 16'h0, 0, 16'h0040, 16'h0000, 0, 16'h0000));
    rows.push_back(mk("edge6_low",  1, 16'h0000, 16'hFFFF, 0, 16'h0, 0, 16'h0040, 16'h0000, 0, 16'h0000));
    rows.push_back(mk("edge6_ovf",  1, 16'h0040, 16'hFFFF, 0, 16'h0, 0, 16'h0040, 16'h0000, 0, 16'h0040));
    rows.push_back(mk("ack6_pulse", 0, 16'h0040, 16'hFFFF, 1, 16'h6, 0, 16'h0000, 16'h0040, 0, 16'h0040));
    foreach (rows[k]) begin
      apply_row(rows[k]);
      e = sb.pop_front();
      checks++;
      if ({pending, any_pending, ack_onehot, ack_error, overflow} !== {e.ep, |e.ep, e.eoh, e.eerr, e.eovf}) begin
        errors++;
        $display("FAIL %s: got pend=%h any=%b oh=%h err=%b ovf=%h want pend=%h oh=%h err=%b ovf=%h",
                 e.nm, pending, any_pending, ack_onehot, ack_error, overflow, e.ep, e.eoh, e.eerr, e.eovf);
      end
    end
    #3 sysreset_n = 1'b0;
    sb.push_back('{"async_reset_mid_ack", 16'h0, 16'h0, 1'b0, 16'h0});
    #1;
    e = sb.pop_front();
    checks++;
    if ({pending, any_pending, ack_onehot, ack_error, overflow} !== {e.ep, |e.ep, e.eoh, e.eerr, e.eovf}) begin
      errors++;
      $display("FAIL %s: got pend=%h any=%b oh=%h err=%b ovf=%h want pend=%h oh=%h err=%b ovf=%h",
               e.nm, pending, any_pending, ack_onehot, ack_error, overflow, e.ep, e.eoh, e.eerr, e.eovf);
    end
    irq_in = 16'h0;
    tick();
    sysreset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mask();
    test_overflow();
    test_set_wins();
    test_bad_ack();
    test_back_to_back();
    test_reset_mid_ack();
    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
